// File: rtl/pattern_collector_pkg.sv
// Shared frame geometry, width helpers and collector FSM encoding for the
// pattern-solver result path.
package pattern_collector_pkg;

  localparam int DEFAULT_PIX_W   = 4;
  localparam int DEFAULT_COLUMNS = 640;
  localparam int DEFAULT_ROWS    = 480;
  localparam int COL_W           = 10;
  localparam int ROW_W           = 10;

  function automatic int calc_addr_w(input int cols, input int rows);
    return $clog2(cols * rows);
  endfunction

  // A single solver still needs a 1-bit index so ports never collapse to zero width
  function automatic int calc_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DEFAULT_ADDR_W = calc_addr_w(DEFAULT_COLUMNS, DEFAULT_ROWS);

  typedef enum logic [1:0] {
    ARB   = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/pattern_collector_if.sv
// Solver result handshake plus frame-buffer write port, bundled for the collector.
interface pattern_collector_if
  import pattern_collector_pkg::*;
#(
  parameter int NUM_SOLVERS = 1,
  parameter int PIX_W       = DEFAULT_PIX_W,
  parameter int ADDR_W      = DEFAULT_ADDR_W
);

  logic [NUM_SOLVERS*PIX_W-1:0] solver_out;
  logic [NUM_SOLVERS-1:0]       solver_ready;
  logic [NUM_SOLVERS-1:0]       solver_continue;
  logic                         wr_en;
  logic [ADDR_W-1:0]            wr_addr;
  logic [PIX_W-1:0]             wr_data;
  logic                         wr_ack;

  modport master (
    input  solver_out,
    input  solver_ready,
    input  wr_ack,
    output solver_continue,
    output wr_en,
    output wr_addr,
    output wr_data
  );

  modport slave (
    output solver_out,
    output solver_ready,
    output wr_ack,
    input  solver_continue,
    input  wr_en,
    input  wr_addr,
    input  wr_data
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first request at or after ptr, wrapping.
module rr_arbiter
  import pattern_collector_pkg::*;
#(
  parameter int N     = 1,
  parameter int IDX_W = calc_idx_w(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] index,
  output logic             any
);

  // Upper pass favours requesters at or above ptr; lower pass provides the wrap
  always_comb begin
    grant = '0;
    index = '0;
    any   = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!any && req[i] && (IDX_W'(i) >= ptr)) begin
        any      = 1'b1;
        grant[i] = 1'b1;
        index    = IDX_W'(i);
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!any && req[i]) begin
        any      = 1'b1;
        grant[i] = 1'b1;
        index    = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/pattern_collector.sv
// Collects interleaved solver results, maps each to its frame-buffer address and
// writes it through a stall-able port, pulsing the owning solver's continue.
module pattern_collector
  import pattern_collector_pkg::*;
#(
  parameter int NUM_SOLVERS = 1,
  parameter int NUM_COLUMNS = DEFAULT_COLUMNS,
  parameter int NUM_ROWS    = DEFAULT_ROWS,
  parameter int PIX_W       = DEFAULT_PIX_W,
  parameter int ADDR_W      = DEFAULT_ADDR_W
) (
  input  logic               clock,
  input  logic               reset,
  pattern_collector_if.master bus,
  output logic               frame_done
);

  localparam int IDX_W = calc_idx_w(NUM_SOLVERS);
  localparam int TOTAL = NUM_COLUMNS * NUM_ROWS;
  localparam int CNT_W = $clog2(TOTAL + 1);
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(1 + (NUM_SOLVERS - 1) * NUM_COLUMNS);

  logic [NUM_SOLVERS-1:0][PIX_W-1:0]  solver_pix;
  logic [NUM_SOLVERS-1:0][ADDR_W-1:0] solver_addr;
  logic [NUM_SOLVERS-1:0]             fin;
  logic [NUM_SOLVERS-1:0]             eligible;
  logic [NUM_SOLVERS-1:0]             advance;
  logic [NUM_SOLVERS-1:0]             arb_grant;
  logic [IDX_W-1:0]                   arb_idx;
  logic                               arb_any;

  state_t            state, state_n;
  logic [IDX_W-1:0]  rr, rr_n;
  logic [IDX_W-1:0]  grant_idx, grant_idx_n;
  logic [CNT_W-1:0]  count, count_n;
  logic              wr_en_q, wr_en_n;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_n;
  logic [PIX_W-1:0]  wr_data_q, wr_data_n;
  logic [NUM_SOLVERS-1:0] cont_q, cont_n;
  logic              done_q, done_n;

  assign solver_pix = bus.solver_out;
  assign eligible   = bus.solver_ready & ~fin;

  // Each solver walks its own rows; stepping rows adds the skipped interleaved rows to addr
  for (genvar i = 0; i < NUM_SOLVERS; i++) begin : g_solver
    logic [COL_W-1:0]  col;
    logic [ROW_W-1:0]  row;
    logic [ROW_W:0]    row_plus_n;
    logic [ADDR_W-1:0] addr;
    logic              fin_q;

    assign row_plus_n = {1'b0, row} + (ROW_W + 1)'(NUM_SOLVERS);

    always_ff @(posedge clock) begin
      if (reset) begin
        col   <= '0;
        row   <= ROW_W'(i);
        addr  <= ADDR_W'(i * NUM_COLUMNS);
        fin_q <= (i >= NUM_ROWS);
      end else if (advance[i]) begin
        if (col == COL_W'(NUM_COLUMNS - 1)) begin
          col  <= '0;
          row  <= row + ROW_W'(NUM_SOLVERS);
          addr <= addr + ROW_STEP;
          if (row_plus_n >= (ROW_W + 1)'(NUM_ROWS))
            fin_q <= 1'b1;
        end else begin
          col  <= col + COL_W'(1);
          addr <= addr + ADDR_W'(1);
        end
      end
    end

    assign solver_addr[i] = addr;
    assign fin[i]         = fin_q;
  end

  rr_arbiter #(.N(NUM_SOLVERS), .IDX_W(IDX_W)) u_arb (
    .req   (eligible),
    .ptr   (rr),
    .grant (arb_grant),
    .index (arb_idx),
    .any   (arb_any)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ARB;
      rr        <= '0;
      grant_idx <= '0;
      count     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      cont_q    <= '0;
      done_q    <= 1'b0;
    end else begin
      state     <= state_n;
      rr        <= rr_n;
      grant_idx <= grant_idx_n;
      count     <= count_n;
      wr_en_q   <= wr_en_n;
      wr_addr_q <= wr_addr_n;
      wr_data_q <= wr_data_n;
      cont_q    <= cont_n;
      done_q    <= done_n;
    end
  end

  // Grant latches the write and pulses continue; the write then holds until acknowledged
  always_comb begin
    state_n     = state;
    rr_n        = rr;
    grant_idx_n = grant_idx;
    count_n     = count;
    wr_en_n     = wr_en_q;
    wr_addr_n   = wr_addr_q;
    wr_data_n   = wr_data_q;
    cont_n      = '0;
    done_n      = done_q;
    advance     = '0;
    case (state)
      ARB: begin
        if (arb_any) begin
          wr_en_n     = 1'b1;
          wr_addr_n   = solver_addr[arb_idx];
          wr_data_n   = solver_pix[arb_idx];
          cont_n      = arb_grant;
          advance     = arb_grant;
          grant_idx_n = arb_idx;
          state_n     = WRITE;
        end
      end
      WRITE: begin
        if (bus.wr_ack) begin
          wr_en_n = 1'b0;
          rr_n    = (grant_idx == IDX_W'(NUM_SOLVERS - 1)) ? '0 : grant_idx + IDX_W'(1);
          count_n = count + CNT_W'(1);
          if (count_n == CNT_W'(TOTAL)) begin
            done_n  = 1'b1;
            state_n = DONE;
          end else begin
            state_n = ARB;
          end
        end
      end
      DONE: begin
        state_n = DONE;
      end
      default: begin
        state_n = ARB;
      end
    endcase
  end

  assign bus.wr_en           = wr_en_q;
  assign bus.wr_addr         = wr_addr_q;
  assign bus.wr_data         = wr_data_q;
  assign bus.solver_continue = cont_q;
  assign frame_done          = done_q;

endmodule

// File: tb/tb_pattern_collector.sv
// Directed bench for pattern_collector: a 2-solver 4x3 frame and a 3-solver 4x4 frame
// fed by counting solver models.
module tb_pattern_collector;
  import pattern_collector_pkg::*;

  localparam int N2 = 2;
  localparam int N3 = 3;
  localparam int AW = 4;
  localparam int PW = 4;

  typedef struct {
    logic [N2-1:0] ready;
    logic          ack;
    int            exp_addr;
    int            exp_data;
    logic [N2-1:0] exp_cont;
  } vec_t;

  logic clock = 1'b0;
  logic reset2;
  logic reset3;
  logic frame_done2;
  logic frame_done3;

  logic [3:0] k2 [N2];
  logic [3:0] k3 [N3];

  int n_compared   = 0;
  int n_mismatched = 0;

  vec_t frame_vec [12];
  int   exp3_addr [16];
  int   exp3_data [16];

  always #5 clock = ~clock;

  pattern_collector_if #(.NUM_SOLVERS(N2), .PIX_W(PW), .ADDR_W(AW)) bus2 ();
  pattern_collector_if #(.NUM_SOLVERS(N3), .PIX_W(PW), .ADDR_W(AW)) bus3 ();

  pattern_collector #(
    .NUM_SOLVERS(N2), .NUM_COLUMNS(4), .NUM_ROWS(3), .PIX_W(PW), .ADDR_W(AW)
  ) dut2 (
    .clock      (clock),
    .reset      (reset2),
    .bus        (bus2),
    .frame_done (frame_done2)
  );

  pattern_collector #(
    .NUM_SOLVERS(N3), .NUM_COLUMNS(4), .NUM_ROWS(4), .PIX_W(PW), .ADDR_W(AW)
  ) dut3 (
    .clock      (clock),
    .reset      (reset3),
    .bus        (bus3),
    .frame_done (frame_done3)
  );

  // Solver i emits k + 5*i for its k-th pixel and moves on when continued
  always @(posedge clock) begin
    for (int i = 0; i < N2; i++) begin
      if (reset2) k2[i] <= 4'd0;
      else if (bus2.solver_continue[i]) k2[i] <= k2[i] + 4'd1;
    end
    for (int i = 0; i < N3; i++) begin
      if (reset3) k3[i] <= 4'd0;
      else if (bus3.solver_continue[i]) k3[i] <= k3[i] + 4'd1;
    end
  end

  assign bus2.solver_out = {k2[1] + 4'd5, k2[0]};
  assign bus3.solver_out = {k3[2] + 4'd10, k3[1] + 4'd5, k3[0]};

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input logic [N2-1:0] ready, input logic ack);
    bus2.solver_ready = ready;
    bus2.wr_ack       = ack;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic run_frame2();
    for (int v = 0; v < 12; v++) begin
      applyStimulus(frame_vec[v].ready, frame_vec[v].ack);
      step();
      checkOutput($sformatf("v%0d wr_en", v), 32'(bus2.wr_en), 32'd1);
      checkOutput($sformatf("v%0d wr_addr", v), 32'(bus2.wr_addr), 32'(frame_vec[v].exp_addr));
      checkOutput($sformatf("v%0d wr_data", v), 32'(bus2.wr_data), 32'(frame_vec[v].exp_data));
      checkOutput($sformatf("v%0d continue", v), 32'(bus2.solver_continue), 32'(frame_vec[v].exp_cont));
      step();
      checkOutput($sformatf("v%0d wr_en gap", v), 32'(bus2.wr_en), 32'd0);
      checkOutput($sformatf("v%0d continue gap", v), 32'(bus2.solver_continue), 32'd0);
      checkOutput($sformatf("v%0d frame_done", v), 32'(frame_done2), (v == 11) ? 32'd1 : 32'd0);
    end
  endtask

  initial begin
    logic [15:0] seen;
    int          cont0_count;

    // Expected write order with both solvers ready and a zero-wait ack
    frame_vec[0]  = '{2'b11, 1'b1, 0,  0, 2'b01};
    frame_vec[1]  = '{2'b11, 1'b1, 4,  5, 2'b10};
    frame_vec[2]  = '{2'b11, 1'b1, 1,  1, 2'b01};
    frame_vec[3]  = '{2'b11, 1'b1, 5,  6, 2'b10};
    frame_vec[4]  = '{2'b11, 1'b1, 2,  2, 2'b01};
    frame_vec[5]  = '{2'b11, 1'b1, 6,  7, 2'b10};
    frame_vec[6]  = '{2'b11, 1'b1, 3,  3, 2'b01};
    frame_vec[7]  = '{2'b11, 1'b1, 7,  8, 2'b10};
    frame_vec[8]  = '{2'b11, 1'b1, 8,  4, 2'b01};
    frame_vec[9]  = '{2'b11, 1'b1, 9,  5, 2'b01};
    frame_vec[10] = '{2'b11, 1'b1, 10, 6, 2'b01};
    frame_vec[11] = '{2'b11, 1'b1, 11, 7, 2'b01};

    exp3_addr = '{0, 4, 8, 1, 5, 9, 2, 6, 10, 3, 7, 11, 12, 13, 14, 15};
    exp3_data = '{0, 5, 10, 1, 6, 11, 2, 7, 12, 3, 8, 13, 4, 5, 6, 7};

    reset2 = 1'b1;
    reset3 = 1'b1;
    applyStimulus(2'b11, 1'b1);
    bus3.solver_ready = 3'b000;
    bus3.wr_ack       = 1'b0;
    step();
    step();
    checkOutput("reset wr_en", 32'(bus2.wr_en), 32'd0);
    checkOutput("reset wr_addr", 32'(bus2.wr_addr), 32'd0);
    checkOutput("reset wr_data", 32'(bus2.wr_data), 32'd0);
    checkOutput("reset continue", 32'(bus2.solver_continue), 32'd0);
    checkOutput("reset frame_done", 32'(frame_done2), 32'd0);

    $display("[TB] full frame, two solvers, zero-wait ack");
    reset2 = 1'b0;
    run_frame2();
    for (int i = 0; i < 3; i++) begin
      step();
      checkOutput("done frame_done", 32'(frame_done2), 32'd1);
      checkOutput("done wr_en", 32'(bus2.wr_en), 32'd0);
      checkOutput("done continue", 32'(bus2.solver_continue), 32'd0);
    end

    $display("[TB] stalled write");
    reset2 = 1'b1;
    applyStimulus(2'b01, 1'b0);
    step();
    reset2 = 1'b0;
    step();
    checkOutput("stall wr_en", 32'(bus2.wr_en), 32'd1);
    checkOutput("stall continue", 32'(bus2.solver_continue), 32'd1);
    for (int i = 0; i < 5; i++) begin
      applyStimulus((i % 2 == 0) ? 2'b11 : 2'b00, 1'b0);
      step();
      checkOutput("stall hold wr_en", 32'(bus2.wr_en), 32'd1);
      checkOutput("stall hold wr_addr", 32'(bus2.wr_addr), 32'd0);
      checkOutput("stall hold wr_data", 32'(bus2.wr_data), 32'd0);
      checkOutput("stall hold continue", 32'(bus2.solver_continue), 32'd0);
    end
    applyStimulus(2'b00, 1'b1);
    step();
    checkOutput("stall ack wr_en", 32'(bus2.wr_en), 32'd0);
    for (int i = 0; i < 2; i++) begin
      step();
      checkOutput("idle ack ignored", 32'(bus2.wr_en), 32'd0);
    end
    applyStimulus(2'b10, 1'b1);
    step();
    checkOutput("after stall s1 addr", 32'(bus2.wr_addr), 32'd4);
    checkOutput("after stall s1 data", 32'(bus2.wr_data), 32'd5);
    checkOutput("after stall s1 continue", 32'(bus2.solver_continue), 32'd2);
    applyStimulus(2'b01, 1'b1);
    step();
    step();
    checkOutput("after stall s0 addr", 32'(bus2.wr_addr), 32'd1);
    checkOutput("after stall s0 data", 32'(bus2.wr_data), 32'd1);

    $display("[TB] reset during write");
    reset2 = 1'b1;
    applyStimulus(2'b11, 1'b1);
    step();
    reset2 = 1'b0;
    for (int i = 0; i < 8; i++) step();
    applyStimulus(2'b11, 1'b0);
    step();
    checkOutput("pre-reset wr_en", 32'(bus2.wr_en), 32'd1);
    checkOutput("pre-reset wr_addr", 32'(bus2.wr_addr), 32'd2);
    reset2 = 1'b1;
    step();
    checkOutput("mid reset wr_en", 32'(bus2.wr_en), 32'd0);
    checkOutput("mid reset frame_done", 32'(frame_done2), 32'd0);
    checkOutput("mid reset wr_addr", 32'(bus2.wr_addr), 32'd0);
    reset2 = 1'b0;
    run_frame2();

    $display("[TB] three solvers, 4x4 frame");
    bus3.solver_ready = 3'b111;
    bus3.wr_ack       = 1'b1;
    step();
    reset3      = 1'b0;
    seen        = '0;
    cont0_count = 0;
    for (int v = 0; v < 16; v++) begin
      step();
      checkOutput($sformatf("n3 v%0d wr_en", v), 32'(bus3.wr_en), 32'd1);
      checkOutput($sformatf("n3 v%0d wr_addr", v), 32'(bus3.wr_addr), 32'(exp3_addr[v]));
      checkOutput($sformatf("n3 v%0d wr_data", v), 32'(bus3.wr_data), 32'(exp3_data[v]));
      if (bus3.solver_continue[0]) cont0_count++;
      seen[bus3.wr_addr] = 1'b1;
      step();
      checkOutput($sformatf("n3 v%0d frame_done", v), 32'(frame_done3), (v == 15) ? 32'd1 : 32'd0);
    end
    checkOutput("n3 coverage", 32'(seen), 32'hFFFF);
    checkOutput("n3 solver0 pixels", 32'(cont0_count), 32'd8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
